grid_scan: RTL

- Downstream display stage for the Game-of-Life CONTROL block.
- Consumes each 64-bit 8x8 generation (registerval) and drives an 8x8 LED matrix by time-multiplexed row scan.
- Generations are double-buffered, so a frame is never torn mid-scan.
- Handles rate mismatch between generation updates and display refresh; also counts displayed frames.

---
 rtl/grid_scan_if.sv | 22 ++
 rtl/grid_scan.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/grid_scan_if.sv
// Generation hand-off from CONTROL plus the LED matrix drive outputs of grid_scan.
// Latency: none, wiring only. Backpressure: grid_ready is advisory; grids offered while it is low are dropped.
interface grid_scan_if;
  logic [63:0] grid_in;
  logic        grid_valid;
  logic        grid_ready;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_start;
  logic [15:0] frame_count;
  logic        stable;

  modport master (
    output grid_in, grid_valid,
    input  grid_ready, row_sel, col_data, frame_start, frame_count, stable
  );

  modport slave (
    input  grid_in, grid_valid,
    output grid_ready, row_sel, col_data, frame_start, frame_count, stable
  );
endinterface

// File: rtl/grid_scan.sv
// Double-buffered 8x8 LED row scanner for Game-of-Life generations; optional GRID_SCAN_STABLE_EN still-life flag.
// Latency: grid accepted at edge t -> frame_start after t+1 -> row 0 lit after t+2; row = DWELL lit + BLANK dark.
// Backpressure: none toward CONTROL; a grid offered while the pending buffer is full is dropped.
module grid_scan #(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic     clk,
  input  logic     reset,
  grid_scan_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_BLANK} state_t;

  localparam int CW = $clog2(DWELL + BLANK + 1);

  state_t        state;
  logic [63:0]   pending;
  logic [63:0]   active;
  logic          pending_full;
  logic [2:0]    row;
  logic [CW-1:0] cnt;

  logic          grid_ready_q;
  logic [7:0]    row_sel_q;
  logic [7:0]    col_data_q;
  logic          frame_start_q;
  logic [15:0]   frame_count_q;

  logic [2:0]    next_row;
  logic          scan_end;
  logic          blank_end;
  logic          row_end;
  logic          load_now;
  logic          capture;

  assign next_row  = row + 3'd1;
  assign scan_end  = (state == S_SCAN)  && (cnt == CW'(DWELL - 1));
  assign blank_end = (state == S_BLANK) && (cnt == CW'(BLANK - 1));
  assign row_end   = (BLANK > 0) ? blank_end : scan_end;
  // Buffer swaps happen only from idle or at the end of row 7, so a frame is never torn.
  assign load_now  = pending_full && ((state == S_IDLE) || (row_end && (row == 3'd7)));
  assign capture   = bus.grid_valid && grid_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      pending       <= '0;
      active        <= '0;
      pending_full  <= 1'b0;
      row           <= '0;
      cnt           <= '0;
      grid_ready_q  <= 1'b1;
      row_sel_q     <= '0;
      col_data_q    <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_start_q <= 1'b0;
      if (load_now) begin
        state         <= S_LOAD;
        active        <= pending;
        pending_full  <= 1'b0;
        grid_ready_q  <= 1'b1;
        frame_start_q <= 1'b1;
        frame_count_q <= frame_count_q + 16'd1;
        row           <= '0;
        cnt           <= '0;
        row_sel_q     <= '0;
        col_data_q    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            row_sel_q  <= '0;
            col_data_q <= '0;
          end
          S_LOAD: begin
            state      <= S_SCAN;
            cnt        <= '0;
            row_sel_q  <= 8'd1;
            col_data_q <= active[7:0];
          end
          S_SCAN: begin
            if (scan_end) begin
              cnt <= '0;
              if (BLANK > 0) begin
                state      <= S_BLANK;
                row_sel_q  <= '0;
                col_data_q <= '0;
              end else begin
                state      <= S_SCAN;
                row        <= next_row;
                row_sel_q  <= 8'd1 << next_row;
                col_data_q <= active[{next_row, 3'b000} +: 8];
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_BLANK: begin
            if (blank_end) begin
              // Row 7 wraps to row 0 here: the frame repeats when nothing is pending.
              cnt        <= '0;
              state      <= S_SCAN;
              row        <= next_row;
              row_sel_q  <= 8'd1 << next_row;
              col_data_q <= active[{next_row, 3'b000} +: 8];
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state      <= S_IDLE;
            row_sel_q  <= '0;
            col_data_q <= '0;
          end
        endcase
      end
      if (capture) begin
        pending      <= bus.grid_in;
        pending_full <= 1'b1;
        grid_ready_q <= 1'b0;
      end
    end
  end

  assign bus.grid_ready  = grid_ready_q;
  assign bus.row_sel     = row_sel_q;
  assign bus.col_data    = col_data_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = frame_count_q;

`ifdef GRID_SCAN_STABLE_EN
  logic stable_q;

  // Compared before the copy, so the first load after reset tests against an all-zero board.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_q <= 1'b0;
    end else if (load_now) begin
      stable_q <= (pending == active);
    end
  end

  assign bus.stable = stable_q;
`else
  assign bus.stable = 1'b0;
`endif

endmodule
